// File: rtl/in_port_req_pkg.sv
// rtl/in_port_req_pkg.sv - shared router constants: directions, header fields, flit width
package in_port_req_pkg;

  // Default flit width in bits
  localparam int DW_DEFAULT = 64;

  // Output direction indices; these are also the bit positions within req/gnt
  localparam int DIR_N  = 4;
  localparam int DIR_S  = 3;
  localparam int DIR_E  = 2;
  localparam int DIR_W  = 1;
  localparam int DIR_PE = 0;

  // Header bit positions inside a flit
  localparam int XDIR_BIT = 55;
  localparam int YDIR_BIT = 54;
  localparam int HX_HI    = 51;
  localparam int HX_LO    = 48;
  localparam int HY_HI    = 47;
  localparam int HY_LO    = 44;

  // Route decision for the head flit
  typedef enum logic [2:0] {
    ROUTE_PE = 3'd0,
    ROUTE_W  = 3'd1,
    ROUTE_E  = 3'd2,
    ROUTE_S  = 3'd3,
    ROUTE_N  = 3'd4
  } route_e;

  // One-hot request vector for a route, ordered {N, S, E, W, PE}
  function automatic logic [4:0] route_onehot(input route_e r);
    logic [4:0] oh;
    oh = 5'b00000;
    case (r)
      ROUTE_N:  oh[DIR_N]  = 1'b1;
      ROUTE_S:  oh[DIR_S]  = 1'b1;
      ROUTE_E:  oh[DIR_E]  = 1'b1;
      ROUTE_W:  oh[DIR_W]  = 1'b1;
      default:  oh[DIR_PE] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/in_port_req_sync_fifo.sv
// rtl/in_port_req_sync_fifo.sv - flit storage FIFO with occupancy count
module sync_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ_q;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from registered occupancy only, so a pop cannot open a slot for a same-cycle push
  assign full  = (occ_q == DEPTH_OCC);
  assign empty = (occ_q == '0);
  assign occ   = occ_q;
  assign rdata = mem[rd_ptr];

  // Writes during reset are dropped; reads of an empty FIFO are ignored
  assign do_push = push && !full && !reset;
  assign do_pop  = pop && !empty;

  // Storage array: written on accepted pushes, never cleared
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/in_port_req.sv
// rtl/in_port_req.sv - router input port: buffers flits, requests an XY route, updates hop field
module in_port_req
  import in_port_req_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic [4:0]              req,
  input  logic [4:0]              gnt,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(DEPTH):0]  occ
);

  logic [DW-1:0] head;
  logic          full;
  logic          empty;
  logic          accept;
  logic [3:0]    hx;
  logic [3:0]    hy;
  route_e        route;
  logic [DW-1:0] head_upd;

  // Acceptance depends only on registered occupancy
  assign in_ready = ~full;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid & in_ready),
    .wdata (in_data),
    .pop   (accept),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .occ   (occ)
  );

  assign hx = head[HX_HI:HX_LO];
  assign hy = head[HY_HI:HY_LO];

  // XY routing: finish the X hops first, then Y, then eject to the local PE
  always_comb begin
    route = ROUTE_PE;
    if (hx != 4'd0) begin
      route = head[XDIR_BIT] ? ROUTE_W : ROUTE_E;
    end else if (hy != 4'd0) begin
      route = head[YDIR_BIT] ? ROUTE_S : ROUTE_N;
    end
  end

  // Request only while a head flit exists; mismatched grant bits never dequeue
  assign req    = empty ? 5'b00000 : route_onehot(route);
  assign accept = |(gnt & req);

  // Consume one hop on the axis being travelled; ejected flits leave untouched
  always_comb begin
    head_upd = head;
    case (route)
      ROUTE_E, ROUTE_W: head_upd[HX_HI:HX_LO] = hx - 4'd1;
      ROUTE_N, ROUTE_S: head_upd[HY_HI:HY_LO] = hy - 4'd1;
      default:          head_upd = head;
    endcase
  end

  // Storage is never cleared, so hide it while the FIFO is empty
  assign out_data = empty ? '0 : head_upd;

endmodule

// File: tb/tb_in_port_req.sv
// tb/tb_in_port_req.sv - self-checking bench for in_port_req: vector table, corner sequences, random vs model
module tb_in_port_req;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  req;
  logic [4:0]  gnt;
  logic [63:0] out_data;
  logic [1:0]  occ;

  int n_vec;
  int n_bad;
  int out_cnt;

  logic [63:0] mq[$];

  in_port_req #(.DW(64), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req      (req),
    .gnt      (gnt),
    .out_data (out_data),
    .occ      (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [4:0]  g;
    logic [4:0]  req;
    logic        rdy;
    logic [1:0]  occ;
    logic [63:0] out;
  } vec_t;

  vec_t tab[16];

  function automatic logic [63:0] mk(input logic xd, input logic yd, input logic [3:0] hx,
                                     input logic [3:0] hy, input logic [31:0] pay);
    return {8'hA5, xd, yd, 2'b10, hx, hy, 12'h5C3, pay};
  endfunction

  function automatic logic [4:0] model_route(input logic [63:0] f);
    int hx, hy;
    hx = int'(f[51:48]);
    hy = int'(f[47:44]);
    if (hx > 0) return f[55] ? 5'b00010 : 5'b00100;
    if (hy > 0) return f[54] ? 5'b01000 : 5'b10000;
    return 5'b00001;
  endfunction

  function automatic logic [63:0] model_out(input logic [63:0] f);
    logic [63:0] r;
    int hx, hy;
    r  = f;
    hx = int'(f[51:48]);
    hy = int'(f[47:44]);
    if (hx > 0)      r[51:48] = 4'(hx - 1);
    else if (hy > 0) r[47:44] = 4'(hy - 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] model_req();
    return (mq.size() == 0) ? 5'b00000 : model_route(mq[0]);
  endfunction

  // One cycle: drive inputs, compare DUT against the queue model, then advance the model
  task automatic step(input logic rst, input logic v, input logic [63:0] d, input logic [4:0] g,
                      input string tag);
    logic [4:0]  ereq;
    logic        erdy;
    logic [63:0] eout;
    int          sz;
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d; gnt = g;
    #1;
    sz   = mq.size();
    ereq = model_req();
    erdy = (sz != DEPTH);
    eout = (sz == 0) ? 64'h0 : model_out(mq[0]);
    chk({tag, "_req"},   64'(req),      64'(ereq));
    chk({tag, "_ready"}, 64'(in_ready), 64'(erdy));
    chk({tag, "_occ"},   64'(occ),      64'(sz));
    chk({tag, "_out"},   out_data,      eout);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if ((g & ereq) != 5'b00000) begin
        void'(mq.pop_front());
        out_cnt++;
      end
      if (v && erdy) mq.push_back(d);
    end
  endtask

  initial begin
    logic [63:0] f1, f2, f3, f4;
    n_vec = 0; n_bad = 0; out_cnt = 0;
    reset = 1'b1; in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF; gnt = 5'b00000;

    f1 = mk(1'b0, 1'b0, 4'd2, 4'd1, 32'h1111_0001);
    f2 = mk(1'b0, 1'b0, 4'd0, 4'd0, 32'h2222_0002);
    f3 = mk(1'b1, 1'b0, 4'd3, 4'd0, 32'h3333_0003);
    f4 = mk(1'b0, 1'b1, 4'd0, 4'd2, 32'h4444_0004);

    // idle, then E flit granted as soon as it requests
    tab[0]  = '{1'b0, 64'h0, 5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    tab[1]  = '{1'b1, f1,    5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    tab[2]  = '{1'b0, 64'h0, 5'b00100, 5'b00100, 1'b1, 2'd1, mk(1'b0, 1'b0, 4'd1, 4'd1, 32'h1111_0001)};
    tab[3]  = '{1'b0, 64'h0, 5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    // PE flit held under a mismatched grant, then released
    tab[4]  = '{1'b1, f2,    5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    tab[5]  = '{1'b0, 64'h0, 5'b10000, 5'b00001, 1'b1, 2'd1, f2};
    tab[6]  = '{1'b0, 64'h0, 5'b10000, 5'b00001, 1'b1, 2'd1, f2};
    tab[7]  = '{1'b0, 64'h0, 5'b10000, 5'b00001, 1'b1, 2'd1, f2};
    tab[8]  = '{1'b0, 64'h0, 5'b00001, 5'b00001, 1'b1, 2'd1, f2};
    tab[9]  = '{1'b0, 64'h0, 5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    // fill to full, then offer a flit while the head is granted: it must be refused
    tab[10] = '{1'b1, f3,    5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};
    tab[11] = '{1'b1, f4,    5'b00000, 5'b00010, 1'b1, 2'd1, mk(1'b1, 1'b0, 4'd2, 4'd0, 32'h3333_0003)};
    tab[12] = '{1'b1, f1,    5'b00010, 5'b00010, 1'b0, 2'd2, mk(1'b1, 1'b0, 4'd2, 4'd0, 32'h3333_0003)};
    tab[13] = '{1'b0, 64'h0, 5'b00000, 5'b01000, 1'b1, 2'd1, mk(1'b0, 1'b1, 4'd0, 4'd1, 32'h4444_0004)};
    tab[14] = '{1'b0, 64'h0, 5'b01000, 5'b01000, 1'b1, 2'd1, mk(1'b0, 1'b1, 4'd0, 4'd1, 32'h4444_0004)};
    tab[15] = '{1'b0, 64'h0, 5'b00000, 5'b00000, 1'b1, 2'd0, 64'h0};

    // enqueue offered during reset must be dropped
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset = 1'b0; in_valid = tab[i].v; in_data = tab[i].d; gnt = tab[i].g;
      #1;
      chk($sformatf("tab%0d_req", i),   64'(req),      64'(tab[i].req));
      chk($sformatf("tab%0d_ready", i), 64'(in_ready), 64'(tab[i].rdy));
      chk($sformatf("tab%0d_occ", i),   64'(occ),      64'(tab[i].occ));
      chk($sformatf("tab%0d_out", i),   out_data,      tab[i].out);
    end

    // stream 8 flits alternating W and S with the grant following req every cycle
    step(1'b1, 1'b0, 64'h0, 5'b00000, "srst");
    out_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      logic [63:0] f;
      f = (i % 2 == 0) ? mk(1'b1, 1'b0, 4'd3, 4'd0, 32'(i)) : mk(1'b0, 1'b1, 4'd0, 4'd2, 32'(i));
      step(1'b0, (i < 8), f, model_req(), $sformatf("stream%0d", i));
    end
    chk("stream_count", 64'(out_cnt), 64'd8);

    // reset lands on the same cycle as a matching grant to a full FIFO
    step(1'b0, 1'b1, f3, 5'b00000, "mr_a");
    step(1'b0, 1'b1, f4, 5'b00000, "mr_b");
    step(1'b1, 1'b1, f1, model_req(), "mr_rst");
    step(1'b0, 1'b0, 64'h0, 5'b00000, "mr_after");
    step(1'b0, 1'b1, f1, 5'b00000, "mr_new");
    step(1'b0, 1'b0, 64'h0, model_req(), "mr_drain");
    step(1'b0, 1'b0, 64'h0, 5'b00000, "mr_idle");

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      logic [63:0] f;
      logic [4:0]  g;
      logic        r;
      int          sel;
      f   = mk(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom);
      sel = $urandom_range(0, 3);
      g   = (sel <= 1) ? model_req() : (sel == 2) ? 5'($urandom) : 5'b00000;
      r   = ($urandom_range(0, 63) == 0);
      step(r, 1'($urandom), f, g, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
